// File: rtl/mips_hs_controller_if.sv
// rtl/mips_hs_controller_if.sv - memory handshake bundle between the multicycle controller and memory
interface mips_hs_controller_if;
   logic mem_ready;
   logic memread;
   logic memwrite;
   logic iord;

   modport master (
      input  mem_ready,
      output memread,
      output memwrite,
      output iord
   );

   modport slave (
      output mem_ready,
      input  memread,
      input  memwrite,
      input  iord
   );
endinterface

// File: rtl/mips_hs_controller.sv
// rtl/mips_hs_controller.sv - multicycle MIPS-subset control unit with mem_ready-stalled memory states
// Optional memory-wait watchdog enabled by defining MIPS_WATCHDOG_EN.
module mips_hs_controller #(
   parameter int FETCH_BEATS = 4,
   parameter int WAIT_MAX    = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [5:0]               op,
   input  logic [5:0]               funct,
   input  logic                     zero,
   mips_hs_controller_if.master     mem,
   output logic                     alusrca,
   output logic [1:0]               alusrcb,
   output logic [2:0]               alucontrol,
   output logic                     memtoreg,
   output logic                     regwrite,
   output logic                     regdst,
   output logic [1:0]               pcsrc,
   output logic                     pcen,
   output logic [FETCH_BEATS-1:0]   irwrite,
   output logic                     illegal_op,
   output logic                     fault,
   output logic [3:0]               state_o
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_LBRD    = 4'd3,
      S_LBWR    = 4'd4,
      S_SBWR    = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWR = 4'd7,
      S_BEQEX   = 4'd8,
      S_BNEEX   = 4'd9,
      S_JEX     = 4'd10,
      S_ADDIEX  = 4'd11,
      S_ADDIWR  = 4'd12,
      S_FAULT   = 4'd15
   } state_t;

   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] LAST_BEAT = 2'(FETCH_BEATS - 1);

   if (FETCH_BEATS < 1 || FETCH_BEATS > 4) begin : g_bad_fetch_beats
      $error("FETCH_BEATS must be in 1..4");
   end
   if (WAIT_MAX < 1) begin : g_bad_wait_max
      $error("WAIT_MAX must be at least 1");
   end

   state_t     state;
   logic [1:0] beat;

`ifdef MIPS_WATCHDOG_EN
   localparam int WCNT_W = $clog2(WAIT_MAX + 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_MAX - 1);

   logic [WCNT_W-1:0] wcnt;
   logic              fault_q;
   logic              mem_wait;

   assign mem_wait = (state == S_FETCH || state == S_LBRD || state == S_SBWR) && !mem.mem_ready;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_FETCH;
         beat  <= 2'd0;
`ifdef MIPS_WATCHDOG_EN
         wcnt    <= '0;
         fault_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_FETCH: begin
               if (mem.mem_ready) begin
                  if (beat == LAST_BEAT) begin
                     beat  <= 2'd0;
                     state <= S_DECODE;
                  end else begin
                     beat <= beat + 2'd1;
                  end
               end
            end
            S_DECODE: begin
               case (op)
                  OP_LB, OP_SB: state <= S_MEMADR;
                  OP_RTYPE:     state <= S_RTYPEEX;
                  OP_BEQ:       state <= S_BEQEX;
                  OP_BNE:       state <= S_BNEEX;
                  OP_J:         state <= S_JEX;
                  OP_ADDI:      state <= S_ADDIEX;
                  default:      state <= S_FETCH;
               endcase
            end
            S_MEMADR: begin
               if (op == OP_LB)      state <= S_LBRD;
               else if (op == OP_SB) state <= S_SBWR;
               else                  state <= S_FETCH;
            end
            S_LBRD:    if (mem.mem_ready) state <= S_LBWR;
            S_LBWR:    state <= S_FETCH;
            S_SBWR:    if (mem.mem_ready) state <= S_FETCH;
            S_RTYPEEX: state <= S_RTYPEWR;
            S_RTYPEWR: state <= S_FETCH;
            S_BEQEX:   state <= S_FETCH;
            S_BNEEX:   state <= S_FETCH;
            S_JEX:     state <= S_FETCH;
            S_ADDIEX:  state <= S_ADDIWR;
            S_ADDIWR:  state <= S_FETCH;
            S_FAULT:   state <= S_FAULT;
            default:   state <= S_FETCH;
         endcase
`ifdef MIPS_WATCHDOG_EN
         // Placed after the case so a timeout overrides any normal transition.
         if (mem_wait) begin
            if (wcnt == WCNT_LAST) begin
               wcnt    <= '0;
               state   <= S_FAULT;
               fault_q <= 1'b1;
            end else begin
               wcnt <= wcnt + 1'b1;
            end
         end else begin
            wcnt <= '0;
         end
`endif
      end
   end

   logic                   memread_c;
   logic                   memwrite_c;
   logic                   iord_c;
   logic                   regwrite_c;
   logic                   pcwrite_c;
   logic                   branch_c;
   logic                   bne_c;
   logic                   illegal_c;
   logic [1:0]             aluop_c;
   logic [FETCH_BEATS-1:0] irw_c;

   always_comb begin
      memread_c  = 1'b0;
      memwrite_c = 1'b0;
      iord_c     = 1'b0;
      regwrite_c = 1'b0;
      pcwrite_c  = 1'b0;
      branch_c   = 1'b0;
      bne_c      = 1'b0;
      illegal_c  = 1'b0;
      aluop_c    = 2'b00;
      irw_c      = '0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      pcsrc      = 2'b00;
      case (state)
         S_FETCH: begin
            memread_c = 1'b1;
            alusrcb   = 2'b01;
            if (mem.mem_ready) begin
               irw_c     = FETCH_BEATS'(1) << beat;
               pcwrite_c = 1'b1;
            end
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_ADDI: illegal_c = 1'b0;
               default: illegal_c = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_LBRD: begin
            memread_c = 1'b1;
            iord_c    = 1'b1;
         end
         S_LBWR: begin
            regwrite_c = 1'b1;
            memtoreg   = 1'b1;
         end
         S_SBWR: begin
            memwrite_c = 1'b1;
            iord_c     = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop_c = 2'b10;
         end
         S_RTYPEWR: begin
            regdst     = 1'b1;
            regwrite_c = 1'b1;
         end
         S_BEQEX, S_BNEEX: begin
            alusrca  = 1'b1;
            aluop_c  = 2'b01;
            branch_c = 1'b1;
            pcsrc    = 2'b01;
            bne_c    = (state == S_BNEEX);
         end
         S_JEX: begin
            pcwrite_c = 1'b1;
            pcsrc     = 2'b10;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWR: begin
            regwrite_c = 1'b1;
         end
         default: begin
            memread_c = 1'b0;
         end
      endcase
   end

   always_comb begin
      alucontrol = 3'b010;
      case (aluop_c)
         2'b00: alucontrol = 3'b010;
         2'b01: alucontrol = 3'b110;
         default: begin
            case (funct)
               6'b100000: alucontrol = 3'b010;
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b101;
            endcase
         end
      endcase
   end

   // Strobes are gated by rst_n so a reset mid-access releases the bus immediately.
   assign mem.memread  = rst_n & memread_c;
   assign mem.memwrite = rst_n & memwrite_c;
   assign mem.iord     = iord_c;
   assign regwrite     = rst_n & regwrite_c;
   assign pcen         = rst_n & (pcwrite_c | (branch_c & (zero ^ bne_c)));
   assign irwrite      = rst_n ? irw_c : '0;
   assign illegal_op   = rst_n & illegal_c;
   assign state_o      = state;

`ifdef MIPS_WATCHDOG_EN
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_mips_hs_controller.sv
// tb/tb_mips_hs_controller.sv - self-checking bench for mips_hs_controller (honours MIPS_WATCHDOG_EN)
module tb_mips_hs_controller;
   localparam int FB = 4;

   localparam logic [5:0] OP_LB   = 6'b100000;
   localparam logic [5:0] OP_SB   = 6'b101000;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [5:0]    op = 6'd0;
   logic [5:0]    funct = 6'd0;
   logic          zero = 1'b0;
   logic          alusrca;
   logic [1:0]    alusrcb;
   logic [2:0]    alucontrol;
   logic          memtoreg;
   logic          regwrite;
   logic          regdst;
   logic [1:0]    pcsrc;
   logic          pcen;
   logic [FB-1:0] irwrite;
   logic          illegal_op;
   logic          fault;
   logic [3:0]    state_o;

   int total = 0;
   int bad = 0;

   mips_hs_controller_if mif ();

   mips_hs_controller #(.FETCH_BEATS(FB), .WAIT_MAX(15)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .mem        (mif.master),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .alucontrol (alucontrol),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .regdst     (regdst),
      .pcsrc      (pcsrc),
      .pcen       (pcen),
      .irwrite    (irwrite),
      .illegal_op (illegal_op),
      .fault      (fault),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  st;
      logic        w;
      logic [19:0] v;
   } ph_t;

   function automatic logic [19:0] mk(input logic mr, mw, io, rw, m2r, rd, asa,
                                      input logic [1:0] asb, input logic [2:0] ac,
                                      input logic [1:0] ps, input logic pe, il,
                                      input logic [3:0] irw);
      return {mr, mw, io, rw, m2r, rd, asa, asb, ac, ps, pe, il, irw};
   endfunction

   function automatic logic [19:0] obs();
      return {mif.memread, mif.memwrite, mif.iord, regwrite, memtoreg, regdst, alusrca,
              alusrcb, alucontrol, pcsrc, pcen, illegal_op, irwrite};
   endfunction

   function automatic ph_t ph(input logic [3:0] st, input logic w, input logic [19:0] v);
      ph_t p;
      p.st = st;
      p.w  = w;
      p.v  = v;
      return p;
   endfunction

   function automatic logic is_legal(input logic [5:0] o);
      return (o == OP_LB || o == OP_SB || o == OP_R || o == OP_BEQ ||
              o == OP_BNE || o == OP_J || o == OP_ADDI);
   endfunction

   function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b101;
      endcase
   endfunction

   task automatic fetch_all();
      mif.mem_ready = 1'b1;
      repeat (FB) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mif.mem_ready = 1'b1;
      op = OP_LB;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (obs() !== mk(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0,4'b0)) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=%h", obs(), mk(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0,4'b0));
      end
      total++;
      if ({state_o, fault} !== {4'd0, 1'b0}) begin
         bad++;
         $display("FAIL reset_state got state=%0d fault=%b want state=0 fault=0", state_o, fault);
      end
      @(negedge clk);
   endtask

   task automatic test_fetch_beats();
      logic [3:0] e;
      rst_n = 1'b1;
      mif.mem_ready = 1'b1;
      op = OP_J;
      for (int b = 0; b < FB; b++) begin
         e = 4'(1 << b);
         #1;
         total++;
         if ({irwrite, pcen, state_o} !== {e, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL fetch_beat%0d got irw=%b pcen=%b st=%0d want irw=%b pcen=1 st=0", b, irwrite, pcen, state_o, e);
         end
         @(negedge clk);
      end
      #1;
      total++;
      if (state_o !== 4'd1) begin
         bad++;
         $display("FAIL fetch_to_decode got st=%0d want 1", state_o);
      end
      @(negedge clk);
      #1;
      total++;
      if ({state_o, pcen, pcsrc} !== {4'd10, 1'b1, 2'b10}) begin
         bad++;
         $display("FAIL jump_ex got st=%0d pcen=%b pcsrc=%b want st=10 pcen=1 pcsrc=10", state_o, pcen, pcsrc);
      end
      @(negedge clk);
   endtask

   task automatic test_fetch_stall();
      op = OP_J;
      mif.mem_ready = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         mif.mem_ready = 1'b0;
         #1;
         total++;
         if ({irwrite, pcen, state_o} !== {4'b0000, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL fetch_stall%0d got irw=%b pcen=%b st=%0d want irw=0000 pcen=0 st=0", s, irwrite, pcen, state_o);
         end
         @(negedge clk);
      end
      mif.mem_ready = 1'b1;
      #1;
      total++;
      if ({irwrite, pcen} !== {4'b0010, 1'b1}) begin
         bad++;
         $display("FAIL fetch_resume got irw=%b pcen=%b want irw=0010 pcen=1", irwrite, pcen);
      end
      repeat (3 + 2) @(negedge clk);
   endtask

   task automatic test_branch();
      logic ep;
      for (int i = 0; i < 4; i++) begin
         op = (i < 2) ? OP_BNE : OP_BEQ;
         zero = (i % 2) == 1;
         ep = (op == OP_BNE) ? !zero : zero;
         fetch_all();
         @(negedge clk);
         #1;
         total++;
         if ({state_o, pcen, pcsrc, alucontrol} !== {(op == OP_BNE) ? 4'd9 : 4'd8, ep, 2'b01, 3'b110}) begin
            bad++;
            $display("FAIL branch op=%b zero=%b got st=%0d pcen=%b pcsrc=%b alu=%b want pcen=%b",
                     op, zero, state_o, pcen, pcsrc, alucontrol, ep);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_addi_rtype();
      op = OP_ADDI;
      fetch_all();
      @(negedge clk);
      #1;
      total++;
      if ({state_o, alusrca, alusrcb, alucontrol} !== {4'd11, 1'b1, 2'b10, 3'b010}) begin
         bad++;
         $display("FAIL addi_ex got st=%0d asa=%b asb=%b alu=%b want 11 1 10 010", state_o, alusrca, alusrcb, alucontrol);
      end
      @(negedge clk);
      #1;
      total++;
      if ({state_o, regwrite, regdst} !== {4'd12, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL addi_wr got st=%0d rw=%b rd=%b want 12 1 0", state_o, regwrite, regdst);
      end
      @(negedge clk);
      #1;
      total++;
      if (state_o !== 4'd0) begin
         bad++;
         $display("FAIL addi_done got st=%0d want 0", state_o);
      end
      op = OP_R;
      funct = 6'b100101;
      fetch_all();
      @(negedge clk);
      #1;
      total++;
      if ({state_o, alucontrol} !== {4'd6, 3'b001}) begin
         bad++;
         $display("FAIL rtype_or got st=%0d alu=%b want 6 001", state_o, alucontrol);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_illegal_and_reset();
      op = 6'b111111;
      fetch_all();
      #1;
      total++;
      if ({state_o, illegal_op} !== {4'd1, 1'b1}) begin
         bad++;
         $display("FAIL illegal_pulse got st=%0d ill=%b want 1 1", state_o, illegal_op);
      end
      @(negedge clk);
      #1;
      total++;
      if ({state_o, illegal_op} !== {4'd0, 1'b0}) begin
         bad++;
         $display("FAIL illegal_after got st=%0d ill=%b want 0 0", state_o, illegal_op);
      end
      op = OP_SB;
      fetch_all();
      repeat (2) @(negedge clk);
      mif.mem_ready = 1'b0;
      #1;
      total++;
      if ({state_o, mif.memwrite} !== {4'd5, 1'b1}) begin
         bad++;
         $display("FAIL sbwr_wait got st=%0d mw=%b want 5 1", state_o, mif.memwrite);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (mif.memwrite !== 1'b0) begin
         bad++;
         $display("FAIL reset_drops_memwrite got mw=%b want 0", mif.memwrite);
      end
      @(negedge clk);
      #1;
      total++;
      if (state_o !== 4'd0) begin
         bad++;
         $display("FAIL reset_from_sbwr got st=%0d want 0", state_o);
      end
      rst_n = 1'b1;
      mif.mem_ready = 1'b1;
   endtask

   task automatic test_watchdog();
      op = OP_LB;
      fetch_all();
      @(negedge clk);
      mif.mem_ready = 1'b0;
      @(negedge clk);
`ifdef MIPS_WATCHDOG_EN
      repeat (14) @(negedge clk);
      #1;
      total++;
      if ({state_o, fault} !== {4'd3, 1'b0}) begin
         bad++;
         $display("FAIL wd_before got st=%0d fault=%b want 3 0", state_o, fault);
      end
      @(negedge clk);
      mif.mem_ready = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      total++;
      if ({state_o, fault, obs()} !== {4'd15, 1'b1, mk(0,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0,4'b0)}) begin
         bad++;
         $display("FAIL wd_fault got st=%0d fault=%b out=%h want 15 1 strobes 0", state_o, fault, obs());
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if ({state_o, fault} !== {4'd0, 1'b0}) begin
         bad++;
         $display("FAIL wd_reset got st=%0d fault=%b want 0 0", state_o, fault);
      end
`else
      repeat (100) @(negedge clk);
      #1;
      total++;
      if ({state_o, fault, mif.memread} !== {4'd3, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL no_wd_wait got st=%0d fault=%b mr=%b want 3 0 1", state_o, fault, mif.memread);
      end
      mif.mem_ready = 1'b1;
      repeat (2) @(negedge clk);
`endif
   endtask

   task automatic test_random();
      ph_t        q[$];
      ph_t        p;
      logic [5:0] rop;
      logic [5:0] fl[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [19:0] ev;
      int         ns;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 7))
            0: rop = OP_LB;
            1: rop = OP_SB;
            2: rop = OP_R;
            3: rop = OP_BEQ;
            4: rop = OP_BNE;
            5: rop = OP_J;
            6: rop = OP_ADDI;
            default: begin
               rop = 6'($urandom);
               while (is_legal(rop)) rop = 6'($urandom);
            end
         endcase
         op = rop;
         funct = ($urandom_range(0, 1) == 1) ? fl[$urandom_range(0, 4)] : 6'($urandom);
         zero = 1'($urandom);
         for (int b = 0; b < FB; b++) begin
            ns = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            for (int s = 0; s <= ns; s++) begin
               mif.mem_ready = (s == ns);
               ev = mk(1,0,0,0,0,0,0,2'b01,3'b010,2'b00,(s == ns),0,(s == ns) ? 4'(1 << b) : 4'b0);
               #1;
               total++;
               if ({state_o, obs()} !== {4'd0, ev}) begin
                  bad++;
                  $display("FAIL rnd_fetch n=%0d beat=%0d got st=%0d out=%h want st=0 out=%h", n, b, state_o, obs(), ev);
               end
               @(negedge clk);
            end
         end
         q.delete();
         q.push_back(ph(4'd1, 0, mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,!is_legal(rop),4'b0)));
         case (rop)
            OP_LB: begin
               q.push_back(ph(4'd2, 0, mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,4'b0)));
               q.push_back(ph(4'd3, 1, mk(1,0,1,0,0,0,0,2'b00,3'b010,2'b00,0,0,4'b0)));
               q.push_back(ph(4'd4, 0, mk(0,0,0,1,1,0,0,2'b00,3'b010,2'b00,0,0,4'b0)));
            end
            OP_SB: begin
               q.push_back(ph(4'd2, 0, mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,4'b0)));
               q.push_back(ph(4'd5, 1, mk(0,1,1,0,0,0,0,2'b00,3'b010,2'b00,0,0,4'b0)));
            end
            OP_R: begin
               q.push_back(ph(4'd6, 0, mk(0,0,0,0,0,0,1,2'b00,alu_of_funct(funct),2'b00,0,0,4'b0)));
               q.push_back(ph(4'd7, 0, mk(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0,4'b0)));
            end
            OP_BEQ: q.push_back(ph(4'd8, 0, mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,zero,0,4'b0)));
            OP_BNE: q.push_back(ph(4'd9, 0, mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,!zero,0,4'b0)));
            OP_J:   q.push_back(ph(4'd10, 0, mk(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0,4'b0)));
            OP_ADDI: begin
               q.push_back(ph(4'd11, 0, mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,4'b0)));
               q.push_back(ph(4'd12, 0, mk(0,0,0,1,0,0,0,2'b00,3'b010,2'b00,0,0,4'b0)));
            end
            default: ;
         endcase
         while (q.size() > 0) begin
            p = q.pop_front();
            ns = p.w ? $urandom_range(0, 3) : 0;
            for (int s = 0; s <= ns; s++) begin
               mif.mem_ready = p.w ? (s == ns) : 1'($urandom);
               #1;
               total++;
               if ({state_o, obs()} !== {p.st, p.v}) begin
                  bad++;
                  $display("FAIL rnd_phase n=%0d op=%b got st=%0d out=%h want st=%0d out=%h", n, rop, state_o, obs(), p.st, p.v);
               end
               @(negedge clk);
            end
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      mif.mem_ready = 1'b0;
      test_reset();
      test_fetch_beats();
      test_fetch_stall();
      test_branch();
      test_addi_rtype();
      test_illegal_and_reset();
      test_watchdog();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
